jtag_scan_ctrl: RTL and testbench

JTAG master scan sequencer for the `tt_um_marxkar_jtag` TAP. It accepts one command at a time: TAP reset, IR scan, DR scan or idle clocks. For each command it generates the TCK/TMS/TDI bit sequence, drives the TAP from Run-Test/Idle to the target shift state and back, and returns the captured TDO bits. It sits between an on-chip command source (host/UART bridge) and the TAP pins.

---
 rtl/jtag_pkg.sv | 37 +++
 rtl/jtag_tck_gen.sv | 40 ++++
 rtl/jtag_scan_ctrl.sv | 175 +++++++++++++++++
 tb/tb_jtag_scan_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared encodings for the JTAG scan sequencer: command ops, FSM states and
// the fixed TMS patterns that walk the TAP between Run-Test/Idle and Shift.
package jtag_pkg;

  typedef enum logic [1:0] {
    OP_RESET = 2'b00,
    OP_IR    = 2'b01,
    OP_DR    = 2'b10,
    OP_IDLE  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_SEQ,
    S_HEADER,
    S_SHIFT,
    S_TRAILER,
    S_RUN,
    S_DONE
  } state_e;

  // TMS patterns are LSB-first and padded to 8 bits so a 3-bit index is exact.
  localparam logic [7:0] RST_TMS    = 8'b0001_1111;
  localparam logic [7:0] IR_HDR_TMS = 8'b0000_0011;
  localparam logic [7:0] DR_HDR_TMS = 8'b0000_0001;
  localparam logic [7:0] TRL_TMS    = 8'b0000_0001;

  localparam int RST_LEN    = 6;
  localparam int IR_HDR_LEN = 4;
  localparam int DR_HDR_LEN = 3;
  localparam int TRL_LEN    = 2;

  function automatic logic is_scan(input op_e op);
    return (op == OP_IR) || (op == OP_DR);
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: TCK_DIV clk cycles low then TCK_DIV high while enabled.
// tck_rise/tck_fall flag the clk edge on which tck is about to toggle.
module jtag_tck_gen #(
  parameter int TCK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic stop,
  output logic tck,
  output logic tck_rise,
  output logic tck_fall
);

  localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TCK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap     = en && (cnt == LAST);
  assign tck_rise = wrap && !tck;
  assign tck_fall = wrap && tck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (stop || !en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (cnt == LAST) begin
      cnt <= '0;
      tck <= ~tck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jtag_scan_ctrl.sv
// JTAG master scan sequencer: one command at a time, TAP parked in Run-Test/Idle
// between commands. Define JTAG_SCAN_AUTO_RESET_EN to prefix an unsynced TAP with a reset.
module jtag_scan_ctrl
  import jtag_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LEN_W   = $clog2(DATA_W + 1),
  parameter int TCK_DIV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_data,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);

`ifdef JTAG_SCAN_AUTO_RESET_EN
  localparam bit AUTO_RST = 1'b1;
`else
  localparam bit AUTO_RST = 1'b0;
`endif

  // Index counter must also cover the 6-step reset pattern.
  localparam int CNT_W = (LEN_W > 3) ? LEN_W : 3;

  state_e            state, state_d;
  logic [CNT_W-1:0]  idx, idx_d, len_m1, hdr_last;
  op_e               op_q, op_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic [DATA_W-1:0] data_q, data_n, cap, dsh;
  logic              synced, set_sync, err_q, set_err, accept, rdy_en;
  logic              tms_d, tdi_d, tck_en, tck_rise, tck_fall;

  function automatic state_e first_state(input op_e op, input logic [LEN_W-1:0] len);
    if (op == OP_IDLE) return (len == '0) ? S_DONE : S_RUN;
    return S_HEADER;
  endfunction

  assign cmd_ready = rdy_en && ((state == S_IDLE) || (state == S_DONE));
  assign rsp_valid = (state == S_DONE);
  assign rsp_err   = rsp_valid && err_q;
  assign tck_en    = state inside {S_RST_SEQ, S_HEADER, S_SHIFT, S_TRAILER, S_RUN};
  assign len_m1    = CNT_W'(len_n) - CNT_W'(1);
  assign hdr_last  = (op_q == OP_IR) ? CNT_W'(IR_HDR_LEN - 1) : CNT_W'(DR_HDR_LEN - 1);

  jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (tck_en),
    .stop     (state_d == S_DONE),
    .tck      (tck),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    op_n     = op_q;
    len_n    = len_q;
    data_n   = data_q;
    accept   = 1'b0;
    set_err  = 1'b0;
    set_sync = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (state == S_DONE) state_d = S_IDLE;
        if (cmd_valid && cmd_ready) begin
          accept = 1'b1;
          op_n   = op_e'(cmd_op);
          len_n  = cmd_len;
          data_n = cmd_data;
          idx_d  = '0;
          if (is_scan(op_n) && ((cmd_len == '0) || (int'(cmd_len) > DATA_W))) begin
            state_d = S_DONE;
            set_err = 1'b1;
          end else if ((op_n == OP_RESET) || (AUTO_RST && !synced)) begin
            state_d = S_RST_SEQ;
          end else begin
            state_d = first_state(op_n, len_n);
          end
        end
      end
      S_RST_SEQ: if (tck_fall) begin
        if (idx == CNT_W'(RST_LEN - 1)) begin
          set_sync = 1'b1;
          idx_d    = '0;
          state_d  = (op_q == OP_RESET) ? S_DONE : first_state(op_q, len_q);
        end else idx_d = idx + 1'b1;
      end
      S_HEADER: if (tck_fall) begin
        if (idx == hdr_last) begin
          idx_d   = '0;
          state_d = S_SHIFT;
        end else idx_d = idx + 1'b1;
      end
      S_SHIFT: if (tck_fall) begin
        if (idx == len_m1) begin
          idx_d   = '0;
          state_d = S_TRAILER;
        end else idx_d = idx + 1'b1;
      end
      S_TRAILER: if (tck_fall) begin
        if (idx == CNT_W'(TRL_LEN - 1)) state_d = S_DONE;
        else idx_d = idx + 1'b1;
      end
      S_RUN: if (tck_fall) begin
        if (idx == len_m1) state_d = S_DONE;
        else idx_d = idx + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Pin values for the position the FSM is entering; they only move on
    // acceptance or tck_fall, i.e. at the start of a low phase.
    tms_d = tms;
    tdi_d = 1'b0;
    dsh   = data_n >> idx_d;
    case (state_d)
      S_RST_SEQ: tms_d = RST_TMS[idx_d[2:0]];
      S_HEADER:  tms_d = (op_n == OP_IR) ? IR_HDR_TMS[idx_d[2:0]] : DR_HDR_TMS[idx_d[2:0]];
      S_SHIFT: begin
        tms_d = (idx_d == len_m1);
        tdi_d = dsh[0];
      end
      S_TRAILER: tms_d = TRL_TMS[idx_d[2:0]];
      S_RUN:     tms_d = 1'b0;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      op_q     <= OP_RESET;
      len_q    <= '0;
      data_q   <= '0;
      cap      <= '0;
      synced   <= 1'b0;
      err_q    <= 1'b0;
      rsp_data <= '0;
      tms      <= 1'b1;
      tdi      <= 1'b0;
      rdy_en   <= 1'b0;
    end else begin
      state  <= state_d;
      idx    <= idx_d;
      op_q   <= op_n;
      len_q  <= len_n;
      data_q <= data_n;
      tms    <= tms_d;
      tdi    <= tdi_d;
      rdy_en <= 1'b1;
      if (set_sync) synced <= 1'b1;
      if (accept) cap <= '0;
      else if ((state == S_SHIFT) && tck_rise) cap <= {tdo, cap[DATA_W-1:1]};
      // Captured bits sit at the top of cap; right-justify them on completion.
      if (state_d == S_DONE) begin
        err_q    <= set_err;
        rsp_data <= (accept || !is_scan(op_q)) ? '0 : (cap >> (DATA_W - int'(len_q)));
      end
    end
  end

endmodule

// File: tb/tb_jtag_scan_ctrl.sv
// Directed bench for jtag_scan_ctrl with a behavioural TAP (IDCODE DR, 2-bit IR).
module tb_jtag_scan_ctrl;

  localparam logic [31:0] IDCODE = 32'h1234_5677;

  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PDR, EX2DR, UPDR,
    SELIR, CAPIR, SHIR, EX1IR, PIR, EX2IR, UPIR
  } tap_e;

  logic        clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [5:0]  cmd_len = '0;
  logic [31:0] cmd_data = '0;
  logic        cmd_ready, rsp_valid, rsp_err, tck, tms, tdi;
  logic [31:0] rsp_data;
  logic        tdo = 1'b0;

  int   ncmp = 0, nerr = 0, cyc = 0;
  tap_e tap = TLR;
  logic [31:0] dr = '0;
  logic [1:0]  ir = '0;
  logic tms_q[$];
  logic tdi_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jtag_scan_ctrl #(.DATA_W(32), .TCK_DIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  function automatic tap_e tap_nxt(input tap_e s, input logic m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR  : PDR;
      PDR:   return m ? EX2DR : PDR;
      EX2DR: return m ? UPDR  : SHDR;
      UPDR:  return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR  : PIR;
      PIR:   return m ? EX2IR : PIR;
      EX2IR: return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    tms_q.push_back(tms);
    tdi_q.push_back(tdi);
    tap <= tap_nxt(tap, tms);
    if (tap == CAPDR) dr <= IDCODE;
    else if (tap == SHDR) dr <= {tdi, dr[31:1]};
    if (tap == CAPIR) ir <= 2'b01;
    else if (tap == SHIR) ir <= {tdi, ir[1]};
  end

  always @(negedge tck)
    tdo <= (tap == SHDR) ? dr[0] : (tap == SHIR) ? ir[0] : 1'b0;

  // Pack TCK history from index s, LSB = first TCK.
  function automatic logic [63:0] trace(input int s, input bit sel_tdi);
    logic [63:0] v;
    v = '0;
    for (int i = s; i < tms_q.size() && (i - s) < 64; i++)
      v = v | (64'(sel_tdi ? tdi_q[i] : tms_q[i]) << (i - s));
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command from a negedge; return at the negedge of the DONE cycle.
  task automatic send(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                      output logic [31:0] d, output logic e, output int lat,
                      output logic busy_ok, output logic rdy, output int acc);
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    acc       = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    cmd_len   = len ^ 6'h3f;
    cmd_data  = ~data;
    busy_ok   = 1'b1;
    n = 0;
    while (!rsp_valid && n < 1000) begin
      if (cmd_ready) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("rsp_valid_seen", 64'(rsp_valid), 64'(1));
    d   = rsp_data;
    e   = rsp_err;
    lat = cyc - acc;
    rdy = cmd_ready;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, lat, acc, done_cyc;
    logic [31:0] d;
    logic e, bok, rdy, seen;

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_err",   64'(rsp_err),   64'(0));
    chk("rst_rsp_data",  64'(rsp_data),  64'(0));
    chk("rst_tck",       64'(tck),       64'(0));
    chk("rst_tms",       64'(tms),       64'(1));
    chk("rst_tdi",       64'(tdi),       64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(cmd_ready), 64'(1));

    // TAP reset
    s = tms_q.size();
    send(2'b00, 6'd0, 32'h0, d, e, lat, bok, rdy, acc);
    chk("reset_tms",   trace(s, 1'b0), 64'h1F);
    chk("reset_ntck",  64'(tms_q.size() - s), 64'(6));
    chk("reset_err",   64'(e), 64'(0));
    chk("reset_busy",  64'(bok), 64'(1));
    chk("reset_lat",   64'(lat), 64'(13));
    chk("reset_tap",   64'(tap), 64'(RTI));

    // IR scan, 2 bits
    s = tms_q.size();
    send(2'b01, 6'd2, 32'h1, d, e, lat, bok, rdy, acc);
    chk("ir_tms",  trace(s, 1'b0), 64'h63);
    chk("ir_tdi",  trace(s, 1'b1), 64'h10);
    chk("ir_ntck", 64'(tms_q.size() - s), 64'(8));
    chk("ir_data", 64'(d), 64'h1);
    chk("ir_lat",  64'(lat), 64'(17));
    chk("ir_tap",  64'(tap), 64'(RTI));

    // DR scan, full width IDCODE
    s = tms_q.size();
    send(2'b10, 6'd32, 32'h0, d, e, lat, bok, rdy, acc);
    done_cyc = cyc;
    chk("dr_tms",   trace(s, 1'b0), 64'h0000_000C_0000_0001);
    chk("dr_tdi",   trace(s, 1'b1), 64'h0);
    chk("dr_ntck",  64'(tms_q.size() - s), 64'(37));
    chk("dr_data",  64'(d), 64'(IDCODE));
    chk("dr_err",   64'(e), 64'(0));
    chk("dr_lat",   64'(lat), 64'(75));
    chk("dr_ready_in_done", 64'(rdy), 64'(1));

    // Back-to-back IDLE clocks
    s = tms_q.size();
    send(2'b11, 6'd5, 32'h0, d, e, lat, bok, rdy, acc);
    chk("idle_b2b_accept", 64'(acc), 64'(done_cyc));
    chk("idle_tms",  trace(s, 1'b0), 64'h0);
    chk("idle_ntck", 64'(tms_q.size() - s), 64'(5));
    chk("idle_lat",  64'(lat), 64'(11));
    chk("idle_ready_in_done", 64'(rdy), 64'(1));
    chk("idle_tap",  64'(tap), 64'(RTI));

    // Illegal scan lengths
    s = tms_q.size();
    send(2'b10, 6'd0, 32'hFFFF_FFFF, d, e, lat, bok, rdy, acc);
    chk("len0_err",  64'(e), 64'(1));
    chk("len0_data", 64'(d), 64'(0));
    chk("len0_lat",  64'(lat), 64'(1));
    send(2'b10, 6'd33, 32'hFFFF_FFFF, d, e, lat, bok, rdy, acc);
    chk("len33_err",  64'(e), 64'(1));
    chk("len33_data", 64'(d), 64'(0));
    chk("err_ntck",   64'(tms_q.size() - s), 64'(0));

    // Abort mid-shift with async reset
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_len   = 6'd32;
    cmd_data  = 32'h0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_tck",       64'(tck),       64'(0));
    chk("abort_tms",       64'(tms),       64'(1));
    chk("abort_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("abort_ready",     64'(cmd_ready), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("abort_no_rsp", 64'(seen), 64'(0));

    s = tms_q.size();
    send(2'b10, 6'd4, 32'hA, d, e, lat, bok, rdy, acc);
`ifdef JTAG_SCAN_AUTO_RESET_EN
    chk("post_tms",  trace(s, 1'b0), 64'h305F);
    chk("post_tdi",  trace(s, 1'b1), 64'h1400);
    chk("post_ntck", 64'(tms_q.size() - s), 64'(15));
    chk("post_lat",  64'(lat), 64'(31));
    chk("post_data", 64'(d), 64'h7);
`else
    chk("post_tms",  trace(s, 1'b0), 64'hC1);
    chk("post_tdi",  trace(s, 1'b1), 64'h50);
    chk("post_ntck", 64'(tms_q.size() - s), 64'(9));
    chk("post_lat",  64'(lat), 64'(19));
`endif
    chk("post_err", 64'(e), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
